apb_arb_master: RTL and testbench
=================================

APB_ARB_MASTER -- requirements
Module: apb_arb_master

Interface
REQ-001 Parameter DWIDTH, default 8, data width of the APB and requester data paths.
REQ-002 Parameter AWIDTH, default 8, address width of the APB and requester address paths.
REQ-003 Parameter TO_CYCLES, default 16, maximum number of ACCESS cycles before a transfer times out; legal range 2..255.
REQ-004 One clock; reset is asynchronous and active-low: PCLK  input  1  clock, all state on rising edge.
REQ-005 PRESETn  input  1  asynchronous active-low reset.
REQ-006 req0, req1  input  1 each  transfer request from requester 0/1, held high until the matching done pulse.
REQ-007 wr0, wr1  input  1 each  1 = write, 0 = read, sampled with the request.
REQ-008 addr0, addr1  input  AWIDTH each  transfer address.
REQ-009 wdata0, wdata1  input  DWIDTH each  write data.
REQ-010 done0, done1  output  1 each  one-cycle completion pulse to requester 0/1.
REQ-011 err  output  1  high together with a done pulse when that transfer timed out.
REQ-012 rdata  output  DWIDTH  read data of the last completed read.
REQ-013 PSEL, PENABLE, PWRITE  output  1 each  APB control.
REQ-014 PADDR  output  AWIDTH  APB address.
REQ-015 PWDATA  output  DWIDTH  APB write data.
REQ-016 PRDATA  input  DWIDTH  APB read data.
REQ-017 PREADY  input  1  APB ready from the slave.

Function
REQ-018 The FSM SHALL have three states: IDLE, SETUP, ACCESS.
REQ-019 In IDLE with no request, the FSM SHALL stay in IDLE with PSEL=0 and PENABLE=0.
REQ-020 In IDLE with any request, the block SHALL select a winner, register its wr/addr/wdata into PWRITE/PADDR/PWDATA, and enter SETUP on the next edge.
REQ-021 Arbitration SHALL be round-robin: with both requests high, the requester not served last wins; a single request wins unconditionally.
REQ-022 The last-served pointer SHALL update only on transfer completion (normal or timeout).
REQ-023 In SETUP, outputs SHALL be PSEL=1, PENABLE=0; the FSM SHALL go to ACCESS after exactly one cycle.
REQ-024 In ACCESS, outputs SHALL be PSEL=1, PENABLE=1; PADDR, PWRITE and PWDATA SHALL stay stable from SETUP until completion.
REQ-025 In ACCESS with PREADY=1, the block SHALL pulse done of the winner for one cycle with err=0 and return to IDLE.
REQ-026 For a completed read, rdata SHALL capture PRDATA on the completing edge; for a write, rdata SHALL be unchanged.
REQ-027 A wait counter SHALL clear on SETUP entry and increment on each ACCESS cycle with PREADY=0.
REQ-028 When the counter equals TO_CYCLES-1 with PREADY=0, the block SHALL pulse done of the winner with err=1, set rdata=0 if the transfer was a read, and return to IDLE.
REQ-029 PREADY=1 on the timeout cycle SHALL take priority, giving normal completion.
REQ-030 Every completed transfer SHALL be followed by at least one IDLE cycle with PSEL=0.
REQ-031 Deasserting req after grant SHALL NOT abort the transfer; the done pulse SHALL still be issued.
REQ-032 done0 and done1 SHALL never be high in the same cycle.
REQ-033 err SHALL be 0 whenever both done signals are 0.
REQ-034 PREADY and PRDATA SHALL be ignored outside ACCESS.

Reset
REQ-035 While PRESETn=0, the FSM SHALL be in IDLE and PSEL, PENABLE, PWRITE, PADDR, PWDATA, rdata, done0, done1, err and the wait counter SHALL all be 0.
REQ-036 On reset, the last-served pointer SHALL indicate requester 1, so requester 0 wins the first contention.
REQ-037 Reset asserted mid-transfer SHALL abort the transfer immediately with no done pulse.

Verification
REQ-038 req0 read, addr0=0x10, PRDATA=0xA5, PREADY=1 -> SETUP 1 cycle, ACCESS 1 cycle, done0 pulse, err=0, rdata=0xA5, PSEL low on the next cycle.
REQ-039 req1 write, addr1=0x22, wdata1=0x3C, PREADY low for 3 ACCESS cycles -> PADDR/PWDATA stable for 4 ACCESS cycles, single done1 pulse, rdata unchanged.
REQ-040 req0 and req1 held high continuously after reset -> grants alternate 0,1,0,1, each transfer separated by 1 IDLE cycle.
REQ-041 Read with PREADY held 0, TO_CYCLES=16 -> done pulse with err=1 after 16 ACCESS cycles, rdata=0x00.
REQ-042 PRESETn pulsed low during ACCESS of a write -> all outputs 0 immediately, no done pulse, next contention won by requester 0.
REQ-043 req0 dropped during SETUP -> transfer still completes and done0 pulses once.

Source files
------------

// File: rtl/apb_arb_master.sv
`default_nettype none
// ============================================================================
//  Module      : apb_arb_master
//  Description : Two-requester round-robin arbiter driving a single APB
//                master port. Each granted transfer runs IDLE -> SETUP ->
//                ACCESS, completes on PREADY or after TO_CYCLES wait cycles
//                (timeout, flagged with err), and returns a one-cycle done
//                pulse to the winning requester.
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_arb_master #(
  parameter int DWIDTH    = 8,
  parameter int AWIDTH    = 8,
  parameter int TO_CYCLES = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              req0,
  input  logic              req1,
  input  logic              wr0,
  input  logic              wr1,
  input  logic [AWIDTH-1:0] addr0,
  input  logic [AWIDTH-1:0] addr1,
  input  logic [DWIDTH-1:0] wdata0,
  input  logic [DWIDTH-1:0] wdata1,
  output logic              done0,
  output logic              done1,
  output logic              err,
  output logic [DWIDTH-1:0] rdata,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [AWIDTH-1:0] PADDR,
  output logic [DWIDTH-1:0] PWDATA,
  input  logic [DWIDTH-1:0] PRDATA,
  input  logic              PREADY
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  // Wait count at which an unanswered ACCESS is abandoned.
  localparam logic [7:0] CNT_LAST = 8'(TO_CYCLES - 1);

  state_t              state_q;
  logic                grant_q;     // requester owning the current transfer
  logic                last_q;      // requester served by the last completed transfer
  logic [7:0]          cnt_q;       // ACCESS wait counter
  logic                psel_q;
  logic                penable_q;
  logic                pwrite_q;
  logic [AWIDTH-1:0]   paddr_q;
  logic [DWIDTH-1:0]   pwdata_q;
  logic [DWIDTH-1:0]   rdata_q;
  logic                done0_q;
  logic                done1_q;
  logic                err_q;

  logic                req0_vld;
  logic                req1_vld;
  logic                any_req;
  logic                grant_d;
  logic                pwrite_d;
  logic [AWIDTH-1:0]   paddr_d;
  logic [DWIDTH-1:0]   pwdata_d;

  // Round-robin winner selection and mux of the winner's request fields.
  // A requester's req is still high during the cycle its done pulse is out
  // (it only reacts on the following edge), so that stale request is masked
  // to avoid re-serving an already completed transfer.
  always_comb begin
    req0_vld = req0 & ~done0_q;
    req1_vld = req1 & ~done1_q;
    any_req  = req0_vld | req1_vld;
    if (req0_vld && req1_vld) begin
      grant_d = ~last_q;
    end else begin
      grant_d = req1_vld;
    end
    pwrite_d = grant_d ? wr1    : wr0;
    paddr_d  = grant_d ? addr1  : addr0;
    pwdata_d = grant_d ? wdata1 : wdata0;
  end

  // Transfer FSM with all APB and requester-side outputs registered.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= ST_IDLE;
      grant_q   <= 1'b0;
      last_q    <= 1'b1;
      cnt_q     <= 8'd0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      rdata_q   <= '0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
          if (any_req) begin
            state_q  <= ST_SETUP;
            grant_q  <= grant_d;
            pwrite_q <= pwrite_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            psel_q   <= 1'b1;
            cnt_q    <= 8'd0;
          end
        end
        ST_SETUP: begin
          state_q   <= ST_ACCESS;
          penable_q <= 1'b1;
        end
        ST_ACCESS: begin
          if (PREADY) begin
            state_q   <= ST_IDLE;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            last_q    <= grant_q;
            done0_q   <= ~grant_q;
            done1_q   <= grant_q;
            if (!pwrite_q) begin
              rdata_q <= PRDATA;
            end
          end else if (cnt_q == CNT_LAST) begin
            // Slave never answered: finish with an error and clear read data.
            state_q   <= ST_IDLE;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            last_q    <= grant_q;
            done0_q   <= ~grant_q;
            done1_q   <= grant_q;
            err_q     <= 1'b1;
            if (!pwrite_q) begin
              rdata_q <= '0;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
        end
      endcase
    end
  end

  assign PSEL    = psel_q;
  assign PENABLE = penable_q;
  assign PWRITE  = pwrite_q;
  assign PADDR   = paddr_q;
  assign PWDATA  = pwdata_q;
  assign rdata   = rdata_q;
  assign done0   = done0_q;
  assign done1   = done1_q;
  assign err     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_arb_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_arb_master
//  Description : Directed self-checking bench for apb_arb_master.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_arb_master;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int TO = 16;

  logic          PCLK = 1'b0;
  logic          PRESETn = 1'b0;
  logic          req0, req1, wr0, wr1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          done0, done1, err;
  logic [DW-1:0] rdata;
  logic          PSEL, PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA;
  logic          PREADY;

  int checks = 0;
  int errors = 0;

  apb_arb_master #(.DWIDTH(DW), .AWIDTH(AW), .TO_CYCLES(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .done0(done0), .done1(done1), .err(err), .rdata(rdata),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;

  task automatic clear_inputs();
    req0 = 0; req1 = 0; wr0 = 0; wr1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    PRDATA = '0; PREADY = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    @(negedge PCLK);
    PRESETn = 0;
    repeat (2) @(negedge PCLK);
    PRESETn = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    PRESETn = 0;
    repeat (2) @(negedge PCLK);
    checks++; if ({PSEL, PENABLE, PWRITE, done0, done1, err} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b exp 000000", {PSEL, PENABLE, PWRITE, done0, done1, err}); end
    checks++; if ({PADDR, PWDATA, rdata} !== 24'h0) begin
      errors++; $display("FAIL reset_data: got %h exp 000000", {PADDR, PWDATA, rdata}); end
    checks++; if (dut.cnt_q !== 8'd0) begin
      errors++; $display("FAIL reset_cnt: got %0d exp 0", dut.cnt_q); end
    PRESETn = 1;
    @(negedge PCLK);
    checks++; if ({PSEL, PENABLE} !== 2'b00) begin
      errors++; $display("FAIL idle_noreq: got %b exp 00", {PSEL, PENABLE}); end
  endtask

  task automatic test_read();
    req0 = 1; wr0 = 0; addr0 = 8'h10; PRDATA = 8'hA5; PREADY = 1;
    @(negedge PCLK);
    checks++; if ({PSEL, PENABLE, PWRITE, PADDR} !== {3'b100, 8'h10}) begin
      errors++; $display("FAIL read_setup: got %b/%h exp 100/10", {PSEL, PENABLE, PWRITE}, PADDR); end
    @(negedge PCLK);
    checks++; if ({PSEL, PENABLE, done0, done1} !== 4'b1100) begin
      errors++; $display("FAIL read_access: got %b exp 1100", {PSEL, PENABLE, done0, done1}); end
    @(negedge PCLK);
    checks++; if ({PSEL, done0, done1, err} !== 4'b0100) begin
      errors++; $display("FAIL read_done: got %b exp 0100", {PSEL, done0, done1, err}); end
    checks++; if (rdata !== 8'hA5) begin
      errors++; $display("FAIL read_rdata: got %h exp a5", rdata); end
    req0 = 0; PREADY = 0;
    @(negedge PCLK);
    checks++; if ({PSEL, done0, done1} !== 3'b000) begin
      errors++; $display("FAIL read_after: got %b exp 000", {PSEL, done0, done1}); end
  endtask

  task automatic test_write_wait();
    req1 = 1; wr1 = 1; addr1 = 8'h22; wdata1 = 8'h3C; PREADY = 0; PRDATA = 8'hFF;
    @(negedge PCLK);
    checks++; if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== {3'b101, 16'h223C}) begin
      errors++; $display("FAIL write_setup: got %b/%h exp 101/223c", {PSEL, PENABLE, PWRITE}, {PADDR, PWDATA}); end
    for (int i = 1; i <= 4; i++) begin
      @(negedge PCLK);
      checks++; if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== {3'b111, 16'h223C}) begin
        errors++; $display("FAIL write_access%0d: got %b/%h exp 111/223c", i, {PSEL, PENABLE, PWRITE}, {PADDR, PWDATA}); end
      checks++; if ({done0, done1} !== 2'b00) begin
        errors++; $display("FAIL write_early_done%0d: got %b exp 00", i, {done0, done1}); end
      if (i == 4) PREADY = 1;
    end
    @(negedge PCLK);
    checks++; if ({done0, done1, err} !== 3'b010) begin
      errors++; $display("FAIL write_done: got %b exp 010", {done0, done1, err}); end
    checks++; if (rdata !== 8'hA5) begin
      errors++; $display("FAIL write_rdata_kept: got %h exp a5", rdata); end
    req1 = 0; PREADY = 0;
    @(negedge PCLK);
    checks++; if ({PSEL, done1} !== 2'b00) begin
      errors++; $display("FAIL write_single_pulse: got %b exp 00", {PSEL, done1}); end
  endtask

  task automatic test_round_robin();
    logic [7:0] ea;
    logic       g1;
    do_reset();
    addr0 = 8'h40; addr1 = 8'h41; wr0 = 0; wr1 = 0; PREADY = 1; PRDATA = 8'h5A;
    req0 = 1; req1 = 1;
    for (int t = 0; t < 4; t++) begin
      g1 = (t % 2) == 1;
      ea = g1 ? 8'h41 : 8'h40;
      @(negedge PCLK);
      checks++; if ({PSEL, PENABLE, PADDR} !== {2'b10, ea}) begin
        errors++; $display("FAIL rr_setup%0d: got %b/%h exp 10/%h", t, {PSEL, PENABLE}, PADDR, ea); end
      @(negedge PCLK);
      checks++; if ({PSEL, PENABLE} !== 2'b11) begin
        errors++; $display("FAIL rr_access%0d: got %b exp 11", t, {PSEL, PENABLE}); end
      @(negedge PCLK);
      checks++; if ({PSEL, done0, done1, err} !== {1'b0, ~g1, g1, 1'b0}) begin
        errors++; $display("FAIL rr_idle_done%0d: got %b exp %b", t, {PSEL, done0, done1, err}, {1'b0, ~g1, g1, 1'b0}); end
      if (t == 3) begin req0 = 0; req1 = 0; end
    end
    @(negedge PCLK);
    checks++; if ({PSEL, done0, done1} !== 3'b000) begin
      errors++; $display("FAIL rr_end: got %b exp 000", {PSEL, done0, done1}); end
    PREADY = 0;
  endtask

  task automatic test_timeout();
    req0 = 1; wr0 = 0; addr0 = 8'h33; PREADY = 0; PRDATA = 8'h77;
    @(negedge PCLK);
    checks++; if ({PSEL, PENABLE} !== 2'b10) begin
      errors++; $display("FAIL to_setup: got %b exp 10", {PSEL, PENABLE}); end
    for (int i = 1; i <= TO; i++) begin
      @(negedge PCLK);
      checks++; if ({PSEL, PENABLE, done0, err} !== 4'b1100) begin
        errors++; $display("FAIL to_wait%0d: got %b exp 1100", i, {PSEL, PENABLE, done0, err}); end
    end
    @(negedge PCLK);
    checks++; if ({PSEL, done0, done1, err} !== 4'b0101) begin
      errors++; $display("FAIL to_done: got %b exp 0101", {PSEL, done0, done1, err}); end
    checks++; if (rdata !== 8'h00) begin
      errors++; $display("FAIL to_rdata: got %h exp 00", rdata); end
    req0 = 0;
    @(negedge PCLK);
    checks++; if ({done0, err} !== 2'b00) begin
      errors++; $display("FAIL to_after: got %b exp 00", {done0, err}); end
  endtask

  task automatic test_ready_on_timeout();
    req0 = 1; wr0 = 0; addr0 = 8'h34; PREADY = 0; PRDATA = 8'hC3;
    @(negedge PCLK);
    for (int i = 1; i <= TO; i++) begin
      @(negedge PCLK);
      checks++; if ({PENABLE, done0} !== 2'b10) begin
        errors++; $display("FAIL rto_wait%0d: got %b exp 10", i, {PENABLE, done0}); end
      if (i == TO) PREADY = 1;
    end
    @(negedge PCLK);
    checks++; if ({done0, err, rdata} !== {2'b10, 8'hC3}) begin
      errors++; $display("FAIL rto_done: got %b/%h exp 10/c3", {done0, err}, rdata); end
    req0 = 0; PREADY = 0;
    @(negedge PCLK);
  endtask

  task automatic test_reset_mid();
    req1 = 1; wr1 = 1; addr1 = 8'h77; wdata1 = 8'h88; PREADY = 0;
    @(negedge PCLK);
    @(negedge PCLK);
    checks++; if ({PSEL, PENABLE, PWRITE} !== 3'b111) begin
      errors++; $display("FAIL rmid_access: got %b exp 111", {PSEL, PENABLE, PWRITE}); end
    PRESETn = 0;
    #1;
    checks++; if ({PSEL, PENABLE, PWRITE, done0, done1, err} !== 6'b0) begin
      errors++; $display("FAIL rmid_ctrl: got %b exp 000000", {PSEL, PENABLE, PWRITE, done0, done1, err}); end
    checks++; if ({PADDR, PWDATA, rdata} !== 24'h0) begin
      errors++; $display("FAIL rmid_data: got %h exp 000000", {PADDR, PWDATA, rdata}); end
    req1 = 0;
    @(negedge PCLK);
    PRESETn = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge PCLK);
      checks++; if ({PSEL, done0, done1} !== 3'b000) begin
        errors++; $display("FAIL rmid_nodone%0d: got %b exp 000", i, {PSEL, done0, done1}); end
    end
    addr0 = 8'h50; addr1 = 8'h51; wr0 = 0; wr1 = 0; req0 = 1; req1 = 1;
    @(negedge PCLK);
    checks++; if ({PSEL, PENABLE, PADDR} !== {2'b10, 8'h50}) begin
      errors++; $display("FAIL rmid_contend: got %b/%h exp 10/50", {PSEL, PENABLE}, PADDR); end
    do_reset();
  endtask

  task automatic test_drop_req();
    req0 = 1; wr0 = 0; addr0 = 8'h60; PREADY = 1; PRDATA = 8'hEE;
    @(negedge PCLK);
    checks++; if ({PSEL, PENABLE, PADDR} !== {2'b10, 8'h60}) begin
      errors++; $display("FAIL drop_setup: got %b/%h exp 10/60", {PSEL, PENABLE}, PADDR); end
    req0 = 0;
    @(negedge PCLK);
    checks++; if ({PSEL, PENABLE, done0} !== 3'b110) begin
      errors++; $display("FAIL drop_access: got %b exp 110", {PSEL, PENABLE, done0}); end
    PRDATA = 8'h99;
    @(negedge PCLK);
    checks++; if ({done0, done1, err, rdata} !== {3'b100, 8'h99}) begin
      errors++; $display("FAIL drop_done: got %b/%h exp 100/99", {done0, done1, err}, rdata); end
    PREADY = 0;
    @(negedge PCLK);
    checks++; if ({PSEL, done0} !== 2'b00) begin
      errors++; $display("FAIL drop_single: got %b exp 00", {PSEL, done0}); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_wait();
    test_round_robin();
    test_timeout();
    test_ready_on_timeout();
    test_reset_mid();
    test_drop_req();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
